// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// The FILL state is only reachable when IMEM_LOADER_FILL_EN is defined.
package imem_pkg;

    localparam int          IMEM_DEPTH_DEF = 128;
    localparam int          CNT_W_DEF      = 16;
    localparam logic [31:0] HALT_INSN      = 32'h00000063;

    typedef enum logic [2:0] {
        CNT_LO = 3'd0,
        CNT_HI = 3'd1,
        DATA   = 3'd2,
        FILL   = 3'd3,
        DONE   = 3'd4,
        ERR    = 3'd5
    } state_t;

    function automatic logic [31:0] word_addr(input logic [31:0] idx);
        return idx << 2;
    endfunction

endpackage

// File: rtl/byte_packer.sv
// Packs a little-endian byte stream into 32-bit words; word_valid is
// asserted combinationally alongside the fourth byte of each word.
module byte_packer (
    input  logic        clk,
    input  logic        i_clear,
    input  logic        i_valid,
    input  logic [7:0]  i_byte,
    output logic        o_word_valid,
    output logic [31:0] o_word
);

    logic [1:0]  r_lane;
    logic [23:0] r_shift;

    // Only the three earlier bytes need storing; the fourth arrives on i_byte.
    always_ff @(posedge clk) begin
        if (i_clear) begin
            r_lane  <= '0;
            r_shift <= '0;
        end else if (i_valid) begin
            r_lane  <= r_lane + 2'd1;
            r_shift <= {i_byte, r_shift[23:8]};
        end
    end

    assign o_word_valid = i_valid && (r_lane == 2'd3);
    assign o_word       = {i_byte, r_shift};

endmodule

// File: rtl/imem_loader.sv
// Boot loader: header word count, then 4N data bytes written to IMEM,
// core held in reset until done. IMEM_LOADER_FILL_EN pads IMEM with halts.
module imem_loader
    import imem_pkg::*;
#(
    parameter int IMEM_DEPTH = IMEM_DEPTH_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rx_valid,
    input  logic [7:0]       rx_data,
    output logic             rx_ready,
    input  logic             reload,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic             cpu_rst_n,
    output logic             load_done,
    output logic             load_err,
    output logic [CNT_W-1:0] words_loaded
);

    state_t           r_state, w_state_next;
    logic [7:0]       r_cnt_lo;
    logic [CNT_W-1:0] r_count, r_words_loaded, w_n_hdr;
    logic             r_mem_we, r_load_done, r_load_err;
    logic [31:0]      r_mem_addr, r_mem_wdata, w_word;
    logic             w_xfer, w_pack_valid, w_clear, w_reload_ok;
    logic             w_word_valid, w_last_word, w_hdr_bad;

    assign w_n_hdr     = CNT_W'({rx_data, r_cnt_lo});
    assign w_hdr_bad   = (w_n_hdr == '0) || (32'(w_n_hdr) > 32'(IMEM_DEPTH));
    assign w_last_word = w_word_valid && (r_words_loaded == r_count - CNT_W'(1));

    byte_packer u_packer (
        .clk          (clk),
        .i_clear      (w_clear),
        .i_valid      (w_pack_valid),
        .i_byte       (rx_data),
        .o_word_valid (w_word_valid),
        .o_word       (w_word)
    );

`ifdef IMEM_LOADER_FILL_EN
    logic [CNT_W-1:0] r_fill_idx;

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_fill_idx <= '0;
        else if (w_last_word)
            r_fill_idx <= r_count;
        else if (r_state == FILL)
            r_fill_idx <= r_fill_idx + CNT_W'(1);
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_state <= CNT_LO;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            CNT_LO: if (w_xfer) w_state_next = CNT_HI;
            CNT_HI: if (w_xfer) w_state_next = w_hdr_bad ? ERR : DATA;
            DATA: begin
                if (w_last_word) begin
`ifdef IMEM_LOADER_FILL_EN
                    w_state_next = (32'(r_count) == 32'(IMEM_DEPTH)) ? DONE : FILL;
`else
                    w_state_next = DONE;
`endif
                end
            end
`ifdef IMEM_LOADER_FILL_EN
            FILL: if (r_fill_idx == CNT_W'(IMEM_DEPTH - 1)) w_state_next = DONE;
`endif
            DONE, ERR: if (reload) w_state_next = CNT_LO;
            default: w_state_next = CNT_LO;
        endcase
    end

    // rx_ready depends on state only, never on rx_valid.
    always_comb begin
        rx_ready = 1'b0;
        case (r_state)
            CNT_LO, CNT_HI, DATA: rx_ready = 1'b1;
            default: rx_ready = 1'b0;
        endcase
        w_reload_ok  = reload && ((r_state == DONE) || (r_state == ERR));
        w_xfer       = rx_valid && rx_ready;
        w_pack_valid = w_xfer && (r_state == DATA);
        w_clear      = !rst_n || w_reload_ok;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt_lo       <= '0;
            r_count        <= '0;
            r_words_loaded <= '0;
            r_mem_we       <= 1'b0;
            r_mem_addr     <= '0;
            r_mem_wdata    <= '0;
            r_load_done    <= 1'b0;
            r_load_err     <= 1'b0;
        end else begin
            r_mem_we <= 1'b0;
            if (w_xfer && (r_state == CNT_LO))
                r_cnt_lo <= rx_data;
            if (w_xfer && (r_state == CNT_HI))
                r_count <= w_n_hdr;
            if (w_word_valid) begin
                r_mem_we       <= 1'b1;
                r_mem_addr     <= word_addr(32'(r_words_loaded));
                r_mem_wdata    <= w_word;
                r_words_loaded <= r_words_loaded + CNT_W'(1);
            end
`ifdef IMEM_LOADER_FILL_EN
            if (r_state == FILL) begin
                r_mem_we    <= 1'b1;
                r_mem_addr  <= word_addr(32'(r_fill_idx));
                r_mem_wdata <= HALT_INSN;
            end
`endif
            if (w_reload_ok)
                r_words_loaded <= '0;
            // Lags DONE by one cycle so the core is released after the final write.
            r_load_done <= (r_state == DONE) && !w_reload_ok;
            r_load_err  <= (w_state_next == ERR);
        end
    end

    assign mem_we       = r_mem_we;
    assign mem_addr     = r_mem_addr;
    assign mem_wdata    = r_mem_wdata;
    assign load_done    = r_load_done;
    assign cpu_rst_n    = r_load_done;
    assign load_err     = r_load_err;
    assign words_loaded = r_words_loaded;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table-driven frames, corner-case
// sequences and random frames checked against a frame-level IMEM model.
module tb_imem_loader;

    localparam int DEPTH = 128;
    localparam int CW    = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          reload = 1'b0;
    logic          rx_ready, mem_we, cpu_rst_n, load_done, load_err;
    logic [31:0]   mem_addr, mem_wdata;
    logic [CW-1:0] words_loaded;

    imem_loader #(.IMEM_DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_ready     (rx_ready),
        .reload       (reload),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .cpu_rst_n    (cpu_rst_n),
        .load_done    (load_done),
        .load_err     (load_err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [31:0] addr; logic [31:0] data; int c; } wr_t;
    typedef struct { logic [31:0] addr; logic [31:0] data; } ew_t;
    typedef struct {
        logic [15:0] hdr;
        int          gap;
        logic [63:0] data;
        bit          rnd;
        bit          exp_err;
        int          exp_wl;
    } vec_t;

    wr_t         wr_log[$];
    int          xfer_log[$];
    ew_t         exp_wr[$];
    logic [7:0]  dq[$];
    logic [31:0] dut_img[DEPTH];
    logic [31:0] exp_img[DEPTH];
    int          done_cyc = -1;
    int          n_chk = 0;
    int          n_pass = 0;
    int          gap_mode = 0;
    bit          rand_reload = 1'b0;
    vec_t        tbl[6];

    // Observe on the falling edge, halfway between active edges.
    always @(negedge clk) begin
        if (mem_we) begin
            wr_log.push_back('{mem_addr, mem_wdata, cyc});
            if (mem_addr[1:0] == 2'b00 && mem_addr < 32'(DEPTH * 4))
                dut_img[mem_addr[8:2]] = mem_wdata;
        end
        if (rx_valid && rx_ready) xfer_log.push_back(cyc);
        if (load_done && done_cyc < 0) done_cyc = cyc;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
        if (rand_reload) reload = ($urandom_range(0, 7) == 0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int g;
        bit ok;
        g  = (gap_mode == 1) ? 1 : ((gap_mode == 2) ? int'($urandom_range(0, 3)) : 0);
        ok = 1'b0;
        for (int i = 0; i < g; i++) begin
            rx_valid = 1'b0;
            tick();
        end
        rx_valid = 1'b1;
        rx_data  = b;
        for (int t = 0; t < 20; t++) begin
            ok = rx_ready;
            tick();
            if (ok) return;
        end
        chk("byte_accept", 64'(ok), 64'(1));
        rx_valid = 1'b0;
    endtask

    task automatic do_reload();
        reload = 1'b1;
        tick();
        reload = 1'b0;
        chk("reload_done",  64'(load_done),    64'(0));
        chk("reload_err",   64'(load_err),     64'(0));
        chk("reload_cpu",   64'(cpu_rst_n),    64'(0));
        chk("reload_words", 64'(words_loaded), 64'(0));
        chk("reload_ready", 64'(rx_ready),     64'(1));
    endtask

    // Frame = 2-byte count + bytes in dq; expectations come from the frame rules.
    task automatic run_frame(input logic [15:0] hdr, input int gm, input bit rr,
                             input bit exp_err, input int exp_wl);
        int n, ew, et, ei, idx;
        bit legal;
        logic [31:0] w;
        n     = int'(hdr);
        legal = (n >= 1) && (n <= DEPTH);
        exp_wr.delete();
        if (legal) begin
            for (int i = 0; i < n; i++) begin
                w = {dq[4*i+3], dq[4*i+2], dq[4*i+1], dq[4*i]};
                exp_wr.push_back('{32'(i * 4), w});
                exp_img[i] = w;
            end
`ifdef IMEM_LOADER_FILL_EN
            for (int i = n; i < DEPTH; i++) begin
                exp_wr.push_back('{32'(i * 4), 32'h00000063});
                exp_img[i] = 32'h00000063;
            end
`endif
        end
        wr_log.delete();
        xfer_log.delete();
        done_cyc    = -1;
        gap_mode    = gm;
        rand_reload = rr;
        send_byte(hdr[7:0]);
        send_byte(hdr[15:8]);
        if (legal)
            for (int i = 0; i < n * 4; i++) send_byte(dq[i]);
        rand_reload = 1'b0;
        reload      = 1'b0;
        rx_valid    = 1'b0;
        if (legal) begin
            for (int t = 0; t < 300 && !load_done; t++) tick();
            tick();
            tick();
        end else begin
            rx_valid = 1'b1;
            rx_data  = 8'hA5;
            for (int t = 0; t < 6; t++) tick();
            chk("err_ready", 64'(rx_ready), 64'(0));
            rx_valid = 1'b0;
            chk("err_xfers", 64'(xfer_log.size()), 64'(2));
        end
        chk("load_err",     64'(load_err),     64'(exp_err));
        chk("load_done",    64'(load_done),    64'(!exp_err));
        chk("cpu_rst_n",    64'(cpu_rst_n),    64'(!exp_err));
        chk("words_loaded", 64'(words_loaded), 64'(exp_wl));
        chk("wr_count",     64'(wr_log.size()), 64'(exp_wr.size()));
        ew = 0;
        for (int i = 0; i < wr_log.size() && i < exp_wr.size(); i++) begin
            if (wr_log[i].addr !== exp_wr[i].addr || wr_log[i].data !== exp_wr[i].data) begin
                if (ew == 0)
                    $display("  first write diff #%0d: addr %h data %h, model addr %h data %h",
                             i, wr_log[i].addr, wr_log[i].data, exp_wr[i].addr, exp_wr[i].data);
                ew++;
            end
        end
        chk("wr_content", 64'(ew), 64'(0));
        if (legal) begin
            et = 0;
            for (int i = 0; i < n; i++) begin
                idx = 4 * i + 5;
                if (idx >= xfer_log.size() || i >= wr_log.size()) et++;
                else if (wr_log[i].c != xfer_log[idx] + 1) et++;
            end
            for (int j = n; j < wr_log.size(); j++)
                if (j > 0 && wr_log[j].c != wr_log[j-1].c + 1) et++;
            if (wr_log.size() == 0 || done_cyc != wr_log[wr_log.size()-1].c + 1) et++;
            chk("timing", 64'(et), 64'(0));
        end
        ei = 0;
        for (int i = 0; i < DEPTH; i++) if (dut_img[i] !== exp_img[i]) ei++;
        chk("image", 64'(ei), 64'(0));
        $display("frame hdr=%04h gap=%0d writes=%0d err=%0d words=%0d",
                 hdr, gm, wr_log.size(), load_err, words_loaded);
        do_reload();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit legal;
        tbl[0] = '{16'h0002, 0, 64'h13000000_93001000, 1'b0, 1'b0, 2};
        tbl[1] = '{16'h0002, 1, 64'h13000000_93001000, 1'b0, 1'b0, 2};
        tbl[2] = '{16'h0000, 0, 64'h0,                 1'b0, 1'b1, 0};
        tbl[3] = '{16'h0081, 0, 64'h0,                 1'b0, 1'b1, 0};
        tbl[4] = '{16'h0080, 2, 64'h0,                 1'b1, 1'b0, 128};
        tbl[5] = '{16'h0100, 0, 64'h0,                 1'b0, 1'b1, 0};
        for (int i = 0; i < DEPTH; i++) begin
            dut_img[i] = 32'h0;
            exp_img[i] = 32'h0;
        end

        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("rst_mem_we",  64'(mem_we),       64'(0));
        chk("rst_addr",    64'(mem_addr),     64'(0));
        chk("rst_wdata",   64'(mem_wdata),    64'(0));
        chk("rst_cpu",     64'(cpu_rst_n),    64'(0));
        chk("rst_done",    64'(load_done),    64'(0));
        chk("rst_err",     64'(load_err),     64'(0));
        chk("rst_words",   64'(words_loaded), 64'(0));
        chk("rst_ready",   64'(rx_ready),     64'(1));
        rst_n = 1'b1;
        tick();

        for (int v = 0; v < 6; v++) begin
            dq.delete();
            if (tbl[v].rnd)
                for (int k = 0; k < 4 * int'(tbl[v].hdr); k++) dq.push_back(8'($urandom));
            else
                for (int k = 0; k < 8; k++) dq.push_back(tbl[v].data[63-8*k -: 8]);
            run_frame(tbl[v].hdr, tbl[v].gap, 1'b0, tbl[v].exp_err, tbl[v].exp_wl);
        end

        // Reset in the middle of word 0 must drop the partial word.
        wr_log.delete();
        gap_mode = 0;
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h11);
        send_byte(8'h22);
        rx_valid = 1'b0;
        rst_n    = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("midrst_writes", 64'(wr_log.size()), 64'(0));
        chk("midrst_ready",  64'(rx_ready),      64'(1));
        chk("midrst_words",  64'(words_loaded),  64'(0));
        chk("midrst_cpu",    64'(cpu_rst_n),     64'(0));
        dq.delete();
        dq.push_back(8'hEF);
        dq.push_back(8'hBE);
        dq.push_back(8'hAD);
        dq.push_back(8'hDE);
        run_frame(16'h0001, 0, 1'b0, 1'b0, 1);
        if (wr_log.size() > 0) chk("deadbeef", 64'(wr_log[0].data), 64'(32'hDEADBEEF));

        for (int r = 0; r < 6; r++) begin
            if ($urandom_range(0, 5) == 0)
                n = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(129, 400));
            else
                n = int'($urandom_range(1, DEPTH));
            legal = (n >= 1) && (n <= DEPTH);
            dq.delete();
            if (legal)
                for (int k = 0; k < 4 * n; k++) dq.push_back(8'($urandom));
            run_frame(16'(n), int'($urandom_range(0, 2)), 1'b1, !legal, legal ? n : 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
